// File: rtl/mac_pkg.sv
// Shared types and width helpers for the bit-serial matrix-vector engine.
package mac_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_MULT,
    S_ACC,
    S_EMIT
  } state_e;

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // $clog2 with a floor of one bit so degenerate sizes still get a real port
  function automatic int clog2_min2(input int v);
    return $clog2(imax(v, 2));
  endfunction

  function automatic int addr_w(input int n_hidden, input int n_in);
    return clog2_min2(n_hidden * n_in);
  endfunction

  function automatic int out_w(input int data_w, input int n_in);
    return 2 * data_w + clog2_min2(n_in);
  endfunction

endpackage

// File: rtl/bit_serial_lane.sv
// One neuron lane: captures weight magnitude/sign, builds the product by
// shift-and-add, then folds the signed product into the running dot product.
module bit_serial_lane
  import mac_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter int OUT_W     = 33,
  localparam int BW       = clog2_min2(DATA_W)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_w,
  input  logic [DATA_W-1:0] w_data,
  input  logic              a_neg,
  input  logic              clr_partial,
  input  logic              mult_en,
  input  logic [BW-1:0]     bit_idx,
  input  logic [DATA_W-1:0] abs_a,
  input  logic              acc_en,
  input  logic              acc_clr,
  output logic [OUT_W-1:0]  acc
);

  logic [DATA_W-1:0]         abs_b_q, abs_b_d;
  logic                      sign_q, sign_d;
  logic [2*DATA_W-1:0]       part_q, part_d;
  logic signed [OUT_W-1:0]   acc_q, acc_d, p_ext;

  always_comb begin
    abs_b_d = abs_b_q;
    sign_d  = sign_q;
    part_d  = part_q;
    acc_d   = acc_q;
    p_ext   = signed'({{(OUT_W-2*DATA_W){1'b0}}, part_q});

    if (load_w) begin
      // magnitude is unsigned so |-2^(DATA_W-1)| still fits
      abs_b_d = w_data[DATA_W-1] ? (~w_data) + DATA_W'(1) : w_data;
      sign_d  = a_neg ^ w_data[DATA_W-1];
    end

    if (clr_partial) begin
      part_d = '0;
    end else if (mult_en && abs_b_q[bit_idx]) begin
      part_d = part_q + ({{DATA_W{1'b0}}, abs_a} << bit_idx);
    end

    if (acc_clr) begin
      acc_d = '0;
    end else if (acc_en) begin
      acc_d = sign_q ? acc_q - p_ext : acc_q + p_ext;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      abs_b_q <= '0;
      sign_q  <= 1'b0;
      part_q  <= '0;
      acc_q   <= '0;
    end else begin
      abs_b_q <= abs_b_d;
      sign_q  <= sign_d;
      part_q  <= part_d;
      acc_q   <= acc_d;
    end
  end

  assign acc = acc_q;

endmodule

// File: rtl/mac_engine.sv
// Weight-stationary fully connected layer: P lanes per neuron group, one
// weight fetched per lane per input, results streamed out one per cycle.
//
//   state   | meaning
//   IDLE    | waiting for start_compute
//   FETCH   | one cycle per lane: read weight, latch |a| and product sign
//   MULT    | one cycle per weight bit: shift-and-add partial products
//   ACC     | fold signed partials into lane accumulators
//   EMIT    | one cycle per valid lane, results in ascending neuron order
module mac_engine
  import mac_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter int PRECISION = DATA_W,
  parameter int N_IN      = 2,
  parameter int N_HIDDEN  = 8,
  parameter int P         = 3,
  localparam int AW       = addr_w(N_HIDDEN, N_IN),
  localparam int OW       = out_w(DATA_W, N_IN)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start_compute,
  input  logic [N_IN*DATA_W-1:0] invec_bus,
  output logic [AW-1:0]          wmem_raddr,
  input  logic [DATA_W-1:0]      wmem_rdata,
  output logic [OW-1:0]          out_data,
  output logic                   out_valid,
  output logic                   busy
);

  localparam int CW = clog2_min2(imax(imax(P, PRECISION), N_HIDDEN + P)) + 1;
  localparam int IW = clog2_min2(N_IN);
  localparam int BW = clog2_min2(DATA_W);

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d, hid_q, hid_d;
  logic [IW-1:0]     inp_q, inp_d;
  logic [DATA_W-1:0] abs_a_q, abs_a_d;
  logic [AW-1:0]     raddr_q, raddr_d;
  logic [OW-1:0]     out_q, out_d;

  logic [CW-1:0]     lane_idx, row, nvalid, emit_idx, hid_next;
  logic [DATA_W-1:0] a_cur, w_lane;
  logic [AW-1:0]     addr_cur;
  logic [BW-1:0]     bit_idx;
  logic [OW-1:0]     acc_mux;
  logic              row_valid, acc_clr, acc_en, mult_en;
  logic [OW-1:0]     acc_lane [P];

  always_comb begin
    a_cur     = invec_bus[int'(inp_q)*DATA_W +: DATA_W];
    lane_idx  = CW'(P-1) - cnt_q;
    row       = hid_q + lane_idx;
    row_valid = row < CW'(N_HIDDEN);
    addr_cur  = AW'(int'(row) * N_IN + int'(inp_q));
    w_lane    = row_valid ? wmem_rdata : '0;
    hid_next  = hid_q + CW'(P);
    nvalid    = (CW'(N_HIDDEN) - hid_q >= CW'(P)) ? CW'(P) : CW'(N_HIDDEN) - hid_q;
    emit_idx  = nvalid - CW'(1) - cnt_q;
    bit_idx   = BW'(CW'(PRECISION-1) - cnt_q);
    acc_mux   = '0;
    for (int l = 0; l < P; l++) begin
      if (emit_idx == CW'(l)) acc_mux = acc_lane[l];
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hid_d   = hid_q;
    inp_d   = inp_q;
    abs_a_d = abs_a_q;
    raddr_d = raddr_q;
    out_d   = out_q;
    acc_clr = 1'b0;
    acc_en  = 1'b0;
    mult_en = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start_compute) begin
          hid_d   = '0;
          inp_d   = '0;
          cnt_d   = CW'(P-1);
          acc_clr = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        abs_a_d = a_cur[DATA_W-1] ? (~a_cur) + DATA_W'(1) : a_cur;
        if (row_valid) raddr_d = addr_cur;
        if (cnt_q == '0) begin
          cnt_d   = CW'(PRECISION-1);
          state_d = S_MULT;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_MULT: begin
        mult_en = 1'b1;
        if (cnt_q == '0) state_d = S_ACC;
        else             cnt_d   = cnt_q - CW'(1);
      end
      S_ACC: begin
        acc_en = 1'b1;
        if (inp_q == IW'(N_IN-1)) begin
          cnt_d   = nvalid - CW'(1);
          state_d = S_EMIT;
        end else begin
          inp_d   = inp_q + IW'(1);
          cnt_d   = CW'(P-1);
          state_d = S_FETCH;
        end
      end
      S_EMIT: begin
        out_d = acc_mux;
        if (cnt_q == '0) begin
          hid_d = hid_next;
          if (hid_next >= CW'(N_HIDDEN)) begin
            state_d = S_IDLE;
          end else begin
            inp_d   = '0;
            cnt_d   = CW'(P-1);
            acc_clr = 1'b1;
            state_d = S_FETCH;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      hid_q   <= '0;
      inp_q   <= '0;
      abs_a_q <= '0;
      raddr_q <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hid_q   <= hid_d;
      inp_q   <= inp_d;
      abs_a_q <= abs_a_d;
      raddr_q <= raddr_d;
      out_q   <= out_d;
    end
  end

  for (genvar l = 0; l < P; l++) begin : g_lane
    bit_serial_lane #(
      .DATA_W (DATA_W),
      .OUT_W  (OW)
    ) u_lane (
      .clk         (clk),
      .rst         (rst),
      .load_w      (state_q == S_FETCH && lane_idx == CW'(l)),
      .w_data      (w_lane),
      .a_neg       (a_cur[DATA_W-1]),
      .clr_partial (state_q == S_FETCH),
      .mult_en     (mult_en),
      .bit_idx     (bit_idx),
      .abs_a       (abs_a_q),
      .acc_en      (acc_en),
      .acc_clr     (acc_clr),
      .acc         (acc_lane[l])
    );
  end

  // Outputs are live during EMIT/FETCH and otherwise hold the last value.
  assign busy       = (state_q != S_IDLE);
  assign out_valid  = (state_q == S_EMIT);
  assign out_data   = out_valid ? acc_mux : out_q;
  assign wmem_raddr = (state_q == S_FETCH && row_valid) ? addr_cur : raddr_q;

endmodule

// File: tb/tb_mac_engine.sv
// Directed bench for mac_engine: weight RAM model, known dot products,
// busy-length, start-while-busy and mid-operation reset behaviour.
module tb_mac_engine;

  localparam int DATA_W = 16;
  localparam int N_IN   = 2;
  localparam int NH     = 8;
  localparam int AW     = 4;
  localparam int OW     = 33;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   start_compute;
  logic [N_IN*DATA_W-1:0] invec_bus;
  logic [AW-1:0]          wmem_raddr;
  logic [DATA_W-1:0]      wmem_rdata;
  logic [OW-1:0]          out_data;
  logic                   out_valid;
  logic                   busy;

  logic [DATA_W-1:0]      wmem [NH*N_IN];
  logic signed [OW-1:0]   exp_v [NH];
  logic [OW-1:0]          got [16];
  int                     n_assert = 0;
  int                     n_fail   = 0;
  int                     nout;
  int                     nbusy;
  int                     a_val [N_IN];
  int                     w_val [NH*N_IN];
  bit                     seen_valid;

  always #5 clk = ~clk;

  assign wmem_rdata = wmem[wmem_raddr];

  mac_engine dut (
    .clk           (clk),
    .rst           (rst),
    .start_compute (start_compute),
    .invec_bus     (invec_bus),
    .wmem_raddr    (wmem_raddr),
    .wmem_rdata    (wmem_rdata),
    .out_data      (out_data),
    .out_valid     (out_valid),
    .busy          (busy)
  );

  task automatic chk(input string tag, input logic signed [63:0] obs,
                     input logic signed [63:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  // Load stimulus into the bus/RAM and build the expected dot products.
  task automatic load_vectors();
    longint s;
    for (int i = 0; i < N_IN; i++) invec_bus[i*DATA_W +: DATA_W] = 16'(a_val[i]);
    for (int k = 0; k < NH*N_IN; k++) wmem[k] = 16'(w_val[k]);
    for (int h = 0; h < NH; h++) begin
      s = 0;
      for (int i = 0; i < N_IN; i++) s += longint'(a_val[i]) * longint'(w_val[h*N_IN+i]);
      exp_v[h] = OW'(s);
    end
  endtask

  task automatic run_job(input bit poke);
    nout  = 0;
    nbusy = 0;
    @(negedge clk) start_compute = 1'b1;
    @(negedge clk) start_compute = 1'b0;
    for (int c = 0; c < 1000; c++) begin
      if (busy) nbusy++;
      if (out_valid) begin
        if (nout < 16) got[nout] = out_data;
        nout++;
      end
      if (!busy) break;
      start_compute = (poke && c == 60);
      @(negedge clk);
    end
    start_compute = 1'b0;
    chk("job_done", 64'(busy), 64'(0));
  endtask

  task automatic check_job(input string tag);
    chk({tag, "_nout"}, 64'(nout), 64'(NH));
    chk({tag, "_busy_cycles"}, 64'(nbusy), 64'(128));
    for (int h = 0; h < NH && h < nout; h++)
      chk($sformatf("%s_out%0d", tag, h), 64'($signed(got[h])), 64'(exp_v[h]));
    chk({tag, "_hold"}, 64'($signed(out_data)), 64'(exp_v[NH-1]));
    chk({tag, "_valid_low"}, 64'(out_valid), 64'(0));
  endtask

  task automatic set_pattern1();
    a_val[0] = 3;
    a_val[1] = -4;
    for (int h = 0; h < NH; h++) begin
      w_val[h*N_IN]     = h + 1;
      w_val[h*N_IN + 1] = -h;
    end
    load_vectors();
  endtask

  initial begin
    rst           = 1'b1;
    start_compute = 1'b0;
    invec_bus     = '0;
    for (int k = 0; k < NH*N_IN; k++) wmem[k] = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_valid", 64'(out_valid), 64'(0));
    chk("rst_data", 64'(out_data), 64'(0));
    chk("rst_raddr", 64'(wmem_raddr), 64'(0));
    rst = 1'b0;
    @(negedge clk);
    chk("idle_busy", 64'(busy), 64'(0));

    // Pattern from hand calculation: 7h+3
    set_pattern1();
    for (int h = 0; h < NH; h++) chk($sformatf("hand_exp%0d", h), 64'(exp_v[h]), 64'(7*h + 3));
    run_job(1'b0);
    check_job("p1");

    // Random small operands
    for (int i = 0; i < N_IN; i++) a_val[i] = int'($urandom_range(400)) - 200;
    for (int k = 0; k < NH*N_IN; k++) w_val[k] = int'($urandom_range(200)) - 100;
    load_vectors();
    run_job(1'b0);
    check_job("rand");

    // Most-negative operands: 2 * 2^30 must not wrap
    for (int i = 0; i < N_IN; i++) a_val[i] = -32768;
    for (int k = 0; k < NH*N_IN; k++) w_val[k] = -32768;
    load_vectors();
    run_job(1'b0);
    check_job("minneg");
    chk("minneg_val", 64'($signed(got[0])), 64'sd2147483648);

    // All zero, with a start pulse injected while busy
    for (int i = 0; i < N_IN; i++) a_val[i] = 0;
    for (int k = 0; k < NH*N_IN; k++) w_val[k] = 0;
    load_vectors();
    run_job(1'b1);
    check_job("zero");
    repeat (3) @(negedge clk);
    chk("zero_no_restart", 64'(busy), 64'(0));

    // Reset in the middle of MULT
    set_pattern1();
    @(negedge clk) start_compute = 1'b1;
    @(negedge clk) start_compute = 1'b0;
    repeat (6) @(negedge clk);
    chk("pre_rst_busy", 64'(busy), 64'(1));
    #1 rst = 1'b1;
    #1;
    chk("midrst_busy", 64'(busy), 64'(0));
    chk("midrst_valid", 64'(out_valid), 64'(0));
    chk("midrst_data", 64'(out_data), 64'(0));
    seen_valid = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (out_valid || busy) seen_valid = 1'b1;
    end
    chk("midrst_quiet", 64'(seen_valid), 64'(0));
    rst = 1'b0;
    @(negedge clk);
    run_job(1'b0);
    check_job("after_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
